// File: rtl/ysyx_22040237_pkg.sv
// Shared definitions for the ysyx_22040237 core: sequencer states, halt codes,
// the reset nop and the decoder's INST_* instruction type codes.
package ysyx_22040237_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } seq_state_t;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'b00,
    HALT_EBREAK  = 2'b01,
    HALT_INVALID = 2'b10,
    HALT_TIMEOUT = 2'b11
  } halt_code_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [2:0] INST_R = 3'd0;
  localparam logic [2:0] INST_I = 3'd1;
  localparam logic [2:0] INST_S = 3'd2;
  localparam logic [2:0] INST_B = 3'd3;
  localparam logic [2:0] INST_U = 3'd4;
  localparam logic [2:0] INST_J = 3'd5;
  localparam logic [2:0] INST_N = 3'd6;

  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic        jump_flag,
                                          input logic [31:0] jump_target);
    return jump_flag ? jump_target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_22040237_pc_reg.sv
// Program counter register: loads the redirect target or pc+4 (wrapping) when
// the sequencer commits an instruction.
module ysyx_22040237_pc_reg
  import ysyx_22040237_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        update,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (update) begin
      pc <= next_pc(pc, jump_flag, jump_target);
    end
  end

endmodule

// File: rtl/ysyx_22040237_core_seq.sv
// Multi-cycle instruction sequencer: fetch, execute, optional load/store, write-back.
// Define YSYX_22040237_FETCH_TMO_EN to halt with code 11 on a stalled fetch.
module ysyx_22040237_core_seq
  import ysyx_22040237_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TMO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ready,
  input  logic        if_rvalid,
  input  logic [31:0] if_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  input  logic        inst_ebreak,
  input  logic        invalid_inst,
  input  logic        mem_op,
  output logic        lsu_req,
  input  logic        lsu_done,
  output logic        wb_en,
  output logic        halt,
  output logic [1:0]  halt_code
);

  seq_state_t state;
  halt_code_t halt_code_q;
  logic       pc_update;
  logic       fetch_done;

  assign pc_update  = (state == ST_WB);
  assign if_addr    = pc;
  assign halt_code  = halt_code_q;
  // Data may arrive in the same cycle the request is accepted, skipping WAIT.
  assign fetch_done = if_rvalid && ((state == ST_WAIT) || (state == ST_FETCH && if_ready));

`ifdef YSYX_22040237_FETCH_TMO_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  // Hit one count early so the counter's all-ones value lands with the HALT entry.
  assign tmo_hit = (tmo_cnt == {{(TMO_W-1){1'b1}}, 1'b0});
`endif

  ysyx_22040237_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .update     (pc_update),
    .jump_flag  (jump_flag),
    .jump_target(jump_target),
    .pc         (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      inst        <= INST_NOP;
      if_req      <= 1'b0;
      lsu_req     <= 1'b0;
      wb_en       <= 1'b0;
      halt        <= 1'b0;
      halt_code_q <= HALT_NONE;
`ifdef YSYX_22040237_FETCH_TMO_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      wb_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if_req <= 1'b1;
          state  <= ST_FETCH;
        end
        ST_FETCH, ST_WAIT: begin
          if (fetch_done) begin
            inst   <= if_rdata;
            if_req <= 1'b0;
            state  <= ST_EXEC;
`ifdef YSYX_22040237_FETCH_TMO_EN
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            tmo_cnt     <= '1;
            if_req      <= 1'b0;
            halt        <= 1'b1;
            halt_code_q <= HALT_TIMEOUT;
            state       <= ST_HALT;
`endif
          end else begin
`ifdef YSYX_22040237_FETCH_TMO_EN
            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
            if (state == ST_FETCH && if_ready) begin
              if_req <= 1'b0;
              state  <= ST_WAIT;
            end
          end
        end
        ST_EXEC: begin
          if (invalid_inst) begin
            halt        <= 1'b1;
            halt_code_q <= HALT_INVALID;
            state       <= ST_HALT;
          end else if (inst_ebreak) begin
            halt        <= 1'b1;
            halt_code_q <= HALT_EBREAK;
            state       <= ST_HALT;
          end else if (mem_op) begin
            lsu_req <= 1'b1;
            state   <= ST_MEM;
          end else begin
            wb_en <= 1'b1;
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (lsu_done) begin
            lsu_req <= 1'b0;
            wb_en   <= 1'b1;
            state   <= ST_WB;
          end
        end
        ST_WB: begin
          if_req <= 1'b1;
          state  <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_core_seq.sv
// Self-checking bench for ysyx_22040237_core_seq: directed sequences, a decode
// priority table and a randomized run against a transaction-level memory/pc model.
module tb_ysyx_22040237_core_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic        inst_ebreak;
  logic        invalid_inst;
  logic        mem_op;
  logic        lsu_req;
  logic        lsu_done;
  logic        wb_en;
  logic        halt;
  logic [1:0]  halt_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22040237_core_seq #(
    .RESET_PC(32'h8000_0000),
    .TMO_W   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ready    (if_ready),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .inst        (inst),
    .pc          (pc),
    .jump_flag   (jump_flag),
    .jump_target (jump_target),
    .inst_ebreak (inst_ebreak),
    .invalid_inst(invalid_inst),
    .mem_op      (mem_op),
    .lsu_req     (lsu_req),
    .lsu_done    (lsu_done),
    .wb_en       (wb_en),
    .halt        (halt),
    .halt_code   (halt_code)
  );

  typedef struct packed {
    logic       inv;
    logic       ebr;
    logic       mem;
    logic       exp_halt;
    logic [1:0] exp_code;
    logic [1:0] exp_wb;
  } hvec_t;

  hvec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    if_ready     = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = 32'h0000_0013;
    jump_flag    = 1'b0;
    jump_target  = 32'h0;
    inst_ebreak  = 1'b0;
    invalid_inst = 1'b0;
    mem_op       = 1'b0;
    lsu_done     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Random-phase model state
  logic        pending, delivered, owed;
  logic        cur_mem, cur_jump;
  logic [31:0] cur_tgt, exp_pc;
  logic        p_req, p_ready, p_rvalid, p_wb;
  logic [31:0] p_rdata;
  int          wb_total, lsu_cnt, wb_cnt, req_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clr_inputs();

    tbl[0] = '{inv: 1'b1, ebr: 1'b1, mem: 1'b1, exp_halt: 1'b1, exp_code: 2'b10, exp_wb: 2'd0};
    tbl[1] = '{inv: 1'b0, ebr: 1'b1, mem: 1'b1, exp_halt: 1'b1, exp_code: 2'b01, exp_wb: 2'd0};
    tbl[2] = '{inv: 1'b1, ebr: 1'b0, mem: 1'b0, exp_halt: 1'b1, exp_code: 2'b10, exp_wb: 2'd0};
    tbl[3] = '{inv: 1'b0, ebr: 1'b1, mem: 1'b0, exp_halt: 1'b1, exp_code: 2'b01, exp_wb: 2'd0};
    tbl[4] = '{inv: 1'b0, ebr: 1'b0, mem: 1'b1, exp_halt: 1'b0, exp_code: 2'b00, exp_wb: 2'd1};
    tbl[5] = '{inv: 1'b0, ebr: 1'b0, mem: 1'b0, exp_halt: 1'b0, exp_code: 2'b00, exp_wb: 2'd1};

    // Reset values
    @(negedge clk);
    chk("rst_if_req", if_req, 0);
    chk("rst_lsu_req", lsu_req, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_halt", halt, 0);
    chk("rst_halt_code", halt_code, 0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0000_0013);

    // Back-to-back addi with zero-wait memory: one instruction every 3 cycles
    do_reset();
    if_ready = 1'b1; if_rvalid = 1'b1; if_rdata = 32'h0000_0093;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("seq_if_req", if_req, 32'(k % 3 == 1));
      chk("seq_wb_en", wb_en, 32'(k % 3 == 0));
      if (k % 3 == 1) chk("seq_if_addr", if_addr, 32'h8000_0000 + 32'(4 * (k / 3)));
      if (k % 3 == 2) chk("seq_inst", inst, 32'h0000_0093);
    end

    // jal redirect, then a jump to the top word and wrap to zero
    do_reset();
    if_ready = 1'b1; if_rvalid = 1'b1; if_rdata = 32'h1000_006f;
    jump_flag = 1'b1; jump_target = 32'h8000_0100;
    cyc(4);
    chk("jmp_if_req", if_req, 1);
    chk("jmp_if_addr", if_addr, 32'h8000_0100);
    jump_target = 32'hFFFF_FFFC;
    cyc(3);
    chk("jmp_top_addr", if_addr, 32'hFFFF_FFFC);
    jump_flag = 1'b0;
    cyc(3);
    chk("wrap_if_addr", if_addr, 32'h0000_0000);
    chk("wrap_pc", pc, 32'h0000_0000);

    // Load with lsu_done on the 4th MEM cycle
    do_reset();
    if_ready = 1'b1; if_rvalid = 1'b1; if_rdata = 32'h0000_2083; mem_op = 1'b1;
    lsu_cnt = 0; wb_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (lsu_req) begin
        lsu_cnt++;
        if_ready = 1'b0; if_rvalid = 1'b0;
      end
      if (wb_en) wb_cnt++;
      lsu_done = lsu_req && (lsu_cnt == 4);
    end
    chk("mem_lsu_cycles", lsu_cnt, 4);
    chk("mem_wb_pulses", wb_cnt, 1);
    chk("mem_pc", pc, 32'h8000_0004);
    chk("mem_if_addr", if_addr, 32'h8000_0004);
    chk("mem_if_req", if_req, 1);
    mem_op = 1'b0;

    // Reset asserted in the middle of MEM, stale handshakes afterwards
    do_reset();
    if_ready = 1'b1; if_rvalid = 1'b1; if_rdata = 32'h0000_0093;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) mem_op = 1'b1;
    end
    chk("rmem_lsu_req", lsu_req, 1);
    chk("rmem_pc_before", pc, 32'h8000_0004);
    rst_n = 1'b0;
    #1;
    chk("rmem_lsu_drop", lsu_req, 0);
    chk("rmem_pc_reset", pc, 32'h8000_0000);
    lsu_done = 1'b1; if_rvalid = 1'b1; if_ready = 1'b0; mem_op = 1'b0;
    if_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmem_refetch_req", if_req, 1);
    chk("rmem_refetch_addr", if_addr, 32'h8000_0000);
    @(negedge clk);
    chk("rmem_no_wb", wb_en, 0);
    chk("rmem_no_lsu", lsu_req, 0);
    chk("rmem_stale_inst", inst, 32'h0000_0013);

    // Decode priority / halt table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      if_ready = 1'b1; if_rvalid = 1'b1; if_rdata = 32'h0010_0073; lsu_done = 1'b1;
      invalid_inst = tbl[i].inv; inst_ebreak = tbl[i].ebr; mem_op = tbl[i].mem;
      wb_cnt = 0; req_cnt = 0;
      for (int k = 1; k <= 22; k++) begin
        @(negedge clk);
        if (k == 2) begin if_ready = 1'b0; if_rvalid = 1'b0; end
        if (wb_en) wb_cnt++;
        if (k >= 3 && if_req) req_cnt++;
      end
      chk("tbl_halt", halt, tbl[i].exp_halt);
      chk("tbl_halt_code", halt_code, tbl[i].exp_code);
      chk("tbl_wb_pulses", wb_cnt, tbl[i].exp_wb);
      chk("tbl_no_fetch", 32'(req_cnt == 0), tbl[i].exp_halt);
      chk("tbl_pc", pc, tbl[i].exp_halt ? 32'h8000_0000 : 32'h8000_0004);
      clr_inputs();
    end

    // Fetch never answered
    do_reset();
`ifdef YSYX_22040237_FETCH_TMO_EN
    cyc(15);
    chk("tmo_not_yet", halt, 0);
    cyc(1);
    chk("tmo_halt", halt, 1);
    chk("tmo_code", halt_code, 2'b11);
    chk("tmo_if_req", if_req, 0);
`else
    cyc(100);
    chk("notmo_halt", halt, 0);
    chk("notmo_if_req", if_req, 1);
    chk("notmo_if_addr", if_addr, 32'h8000_0000);
`endif

    // Randomized run against the memory/pc scoreboard
    do_reset();
    pending = 1'b0; owed = 1'b0; exp_pc = 32'h8000_0000;
    cur_mem = 1'b0; cur_jump = 1'b0; cur_tgt = 32'h0;
    p_req = 1'b0; p_ready = 1'b0; p_rvalid = 1'b0; p_rdata = 32'h0; p_wb = 1'b0;
    wb_total = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      delivered = 1'b0;
      if (p_req && p_ready && p_rvalid) begin
        delivered = 1'b1;
      end else if (p_req && p_ready) begin
        pending = 1'b1;
      end else if (pending && p_rvalid) begin
        delivered = 1'b1;
        pending   = 1'b0;
      end
      if (p_wb) begin
        exp_pc = cur_jump ? cur_tgt : exp_pc + 32'd4;
        chk("rnd_wb_owed", owed, 1);
        owed = 1'b0;
        wb_total++;
        chk("rnd_pc", pc, exp_pc);
      end
      if (delivered) begin
        chk("rnd_inst", inst, p_rdata);
        chk("rnd_fetch_owed", owed, 0);
        owed     = 1'b1;
        cur_mem  = ($urandom % 3) == 0;
        cur_jump = ($urandom % 4) == 0;
        cur_tgt  = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
        mem_op = cur_mem; jump_flag = cur_jump; jump_target = cur_tgt;
      end
      if (if_req) chk("rnd_if_addr", if_addr, exp_pc);
      if (lsu_req) chk("rnd_lsu_req", cur_mem, 1);
      if_ready  = $urandom % 2;
      if_rvalid = ($urandom % 3) == 0;
      if_rdata  = $urandom;
      lsu_done  = ($urandom % 3) == 0;
      p_req = if_req; p_ready = if_ready; p_rvalid = if_rvalid;
      p_rdata = if_rdata; p_wb = wb_en;
    end
    chk("rnd_progress", 32'(wb_total > 100), 1);
    chk("rnd_no_halt", halt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
